// File: rtl/jt49_cen_pkg.sv
// jt49_cen_pkg: shared mode encoding and default widths for the JT49 clock-enable generator
package jt49_cen_pkg;
    typedef enum logic {
        CEN_MODE_INT  = 1'b0,
        CEN_MODE_FRAC = 1'b1
    } cen_mode_e;
    localparam int CEN_DW = 4;
    localparam int CEN_FW = 12;
endpackage

// File: rtl/jt49_cengen_if.sv
// jt49_cengen_if: host-side controls and divided enable outputs of the clock-enable generator
interface jt49_cengen_if
    import jt49_cen_pkg::*;
#(
    parameter int DW = CEN_DW,
    parameter int FW = CEN_FW
);
    logic          cen;
    logic          mode;
    logic [DW-1:0] div;
    logic [FW-1:0] num;
    logic [FW-1:0] den;
    logic          sync;
    logic          cen_out;
    logic          cen_half;
    modport master (
        output cen, mode, div, num, den, sync,
        input  cen_out, cen_half
    );
    modport slave (
        input  cen, mode, div, num, den, sync,
        output cen_out, cen_half
    );
endinterface

// File: rtl/jt49_cen_frac.sv
// jt49_cen_frac: NUM/DEN fractional enable divider; hit is combinational from the accumulator
module jt49_cen_frac
    import jt49_cen_pkg::*;
#(
    parameter int FW = CEN_FW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic          sync,
    input  logic [FW-1:0] num,
    input  logic [FW-1:0] den,
    output logic          hit
);
    logic [FW:0]   acc_q, acc_d, acc_e, sum;
    logic [FW-1:0] num_c;
    // acc stays below den, and num_c <= den, so sum fits in FW+1 bits
    always_comb begin
        num_c = (num < den) ? num : den;
        acc_e = sync ? '0 : acc_q;
        sum   = acc_e + {1'b0, num_c};
        hit   = (den != '0) && (sum >= {1'b0, den});
        acc_d = !cen ? acc_e : (den == '0) ? '0 : hit ? sum - {1'b0, den} : sum;
    end
    always_ff @(posedge clk) begin
        if (rst) acc_q <= '0;
        else     acc_q <= acc_d;
    end
endmodule

// File: rtl/jt49_cengen.sv
// jt49_cengen: divides a base clock enable by an integer or a NUM/DEN ratio,
// with registered single-cycle cen_out and a divide-by-2 cen_half tap.
module jt49_cengen
    import jt49_cen_pkg::*;
#(
    parameter int DW = CEN_DW,
    parameter int FW = CEN_FW
) (
    input logic          clk,
    input logic          rst,
    jt49_cengen_if.slave bus
);
    logic [DW-1:0] cnt_q, cnt_d, cnt_e, div_l_q, div_l_d, div_e;
    logic          wrap, hit_int, hit_frac, hit, ph_q, ph_d, ph_e;
    logic          cen_out_q, cen_half_q;
    jt49_cen_frac #(.FW(FW)) u_frac (
        .clk  (clk),
        .rst  (rst),
        .cen  (bus.cen),
        .sync (bus.sync),
        .num  (bus.num),
        .den  (bus.den),
        .hit  (hit_frac)
    );
    // sync makes this cycle's cen see the cleared counter and freshly loaded divisor
    always_comb begin
        cnt_e   = bus.sync ? '0 : cnt_q;
        div_e   = bus.sync ? bus.div : div_l_q;
        wrap    = cnt_e == div_e;
        hit_int = cnt_e == '0;
        cnt_d   = bus.cen ? (wrap ? '0 : cnt_e + 1'b1) : cnt_e;
        div_l_d = (bus.sync || (bus.cen && wrap)) ? bus.div : div_l_q;
        hit     = bus.cen && ((bus.mode == CEN_MODE_FRAC) ? hit_frac : hit_int);
        ph_e    = bus.sync ? 1'b0 : ph_q;
        ph_d    = ph_e ^ hit;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            div_l_q    <= bus.div;
            ph_q       <= 1'b0;
            cen_out_q  <= 1'b0;
            cen_half_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            div_l_q    <= div_l_d;
            ph_q       <= ph_d;
            cen_out_q  <= hit;
            cen_half_q <= hit && !ph_e;
        end
    end
    assign bus.cen_out  = cen_out_q;
    assign bus.cen_half = cen_half_q;
endmodule

// File: tb/tb_jt49_cengen.sv
// tb_jt49_cengen: directed stimulus with a ratio-level reference model checked every cycle
module tb_jt49_cengen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_pass = 0;
    bit   cmp_en = 1'b0;
    jt49_cengen_if #(.DW(4), .FW(12)) bus ();
    jt49_cengen #(.DW(4), .FW(12)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask
    // Reference: integer mode hits on the first cen of each period of div+1 cens,
    // the period length latched at period start; fractional mode hits on the k-th cen
    // since restart exactly when floor(k*num_c/den) increases.
    int m_pos, m_per, m_k;
    bit m_ph, e_out, e_half;
    always @(posedge clk) begin
        bit h;
        int nc;
        if (rst) begin
            m_pos = 0; m_per = int'(bus.div) + 1; m_k = 0; m_ph = 0;
            e_out = 0; e_half = 0;
        end else begin
            if (bus.sync) begin
                m_pos = 0; m_per = int'(bus.div) + 1; m_k = 0; m_ph = 0;
            end
            h = 0;
            if (bus.cen) begin
                bit hi, hf;
                hi = (m_pos == 0);
                m_pos++;
                if (m_pos == m_per) begin
                    m_pos = 0;
                    m_per = int'(bus.div) + 1;
                end
                nc = (bus.num < bus.den) ? int'(bus.num) : int'(bus.den);
                if (bus.den == 0) begin
                    hf = 0; m_k = 0;
                end else begin
                    m_k++;
                    hf = ((m_k * nc) / int'(bus.den)) != (((m_k - 1) * nc) / int'(bus.den));
                end
                h = bus.mode ? hf : hi;
            end
            e_half = h && !m_ph;
            if (h) m_ph = !m_ph;
            e_out = h;
        end
    end
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_cen_out", int'(bus.cen_out), int'(e_out));
            chk("model_cen_half", int'(bus.cen_half), int'(e_half));
        end
    end
    initial begin
        logic [15:0] outs, halfs;
        int np, bad, last, first, hf;
        bus.cen = 0; bus.mode = 0; bus.div = 4'd3; bus.num = '0; bus.den = '0; bus.sync = 0;
        rst = 1;
        step();
        cmp_en = 1;
        chk("reset_out", int'(bus.cen_out), 0);
        chk("reset_half", int'(bus.cen_half), 0);
        rst = 0;
        bus.cen = 1;
        for (int i = 0; i < 16; i++) begin
            step();
            outs[i] = bus.cen_out;
            halfs[i] = bus.cen_half;
        end
        chk("int_div3_out_mask", int'(outs), 'h1111);
        chk("int_div3_half_mask", int'(halfs), 'h0101);
        outs = '0;
        for (int j = 0; j < 10; j++) begin
            if (j == 2) bus.div = 4'd1;
            bus.cen = 1;
            step();
            outs[j] = bus.cen_out;
            bus.cen = 0;
            step();
        end
        chk("div_change_mask", int'(outs), 'h151);
        bus.mode = 1; bus.num = 12'd3; bus.den = 12'd8; bus.sync = 1; bus.cen = 0;
        step();
        bus.sync = 0; bus.cen = 1;
        np = 0; bad = 0; last = -1;
        for (int i = 0; i < 800; i++) begin
            step();
            if (bus.cen_out) begin
                np++;
                if (last >= 0 && (i - last) != 2 && (i - last) != 3) bad++;
                last = i;
            end
        end
        chk("frac_3_8_pulses", np, 300);
        chk("frac_3_8_bad_gaps", bad, 0);
        bus.den = 12'd0;
        np = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            np += int'(bus.cen_out);
        end
        chk("frac_den0_pulses", np, 0);
        bus.num = 12'd10; bus.den = 12'd8;
        np = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            np += int'(bus.cen_out);
        end
        chk("frac_num_gt_den_pulses", np, 20);
        bus.num = 12'd1; bus.sync = 1; bus.cen = 0;
        step();
        bus.sync = 0; bus.cen = 1;
        np = 0; first = 0;
        for (int i = 1; i <= 16; i++) begin
            step();
            if (bus.cen_out) begin
                np++;
                if (first == 0) first = i;
            end
        end
        chk("frac_1_8_first_pulse", first, 8);
        chk("frac_1_8_pulses", np, 2);
        bus.mode = 0; bus.div = 4'd5; bus.sync = 1; bus.cen = 0;
        step();
        bus.sync = 0; bus.cen = 1;
        repeat (3) step();
        bus.sync = 1;
        step();
        chk("sync_cen_out", int'(bus.cen_out), 1);
        chk("sync_cen_half", int'(bus.cen_half), 1);
        bus.sync = 0;
        first = 0; hf = -1;
        for (int i = 1; i <= 20 && first == 0; i++) begin
            step();
            if (bus.cen_out) begin
                first = i;
                hf = int'(bus.cen_half);
            end
        end
        chk("sync_next_hit", first, 6);
        chk("sync_next_half", hf, 0);
        bus.div = 4'd15; bus.sync = 1; bus.cen = 0;
        step();
        bus.sync = 0; bus.cen = 1;
        np = 0;
        for (int i = 0; i < 32; i++) begin
            step();
            np += int'(bus.cen_out);
        end
        chk("int_div15_pulses", np, 2);
        bus.div = 4'd3;
        repeat (2) step();
        rst = 1;
        step();
        chk("rst_mid_out", int'(bus.cen_out), 0);
        chk("rst_mid_half", int'(bus.cen_half), 0);
        rst = 0;
        step();
        chk("post_rst_out", int'(bus.cen_out), 1);
        chk("post_rst_half", int'(bus.cen_half), 1);
        cmp_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
